blackjack_table_ctrl: RTL and testbench

Parametrised blackjack round controller for one dealer and `NUM_PLAYERS` players; next generation of the single-player game FSM. It sequences shuffle, the opening deal, each player's hit/stay turn, the dealer's draw, and per-player settlement. It sits between the debounced front-panel buttons and the deck shuffler and card adder, and contains its own display-hold timer.

---
 rtl/blackjack_pkg.sv | 17 +
 rtl/hold_timer.sv | 40 ++++
 rtl/blackjack_table_ctrl.sv | 178 +++++++++++++++++
 tb/tb_blackjack_table_ctrl.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/blackjack_pkg.sv
// Shared types and constants for the blackjack table controller.
package blackjack_pkg;

    typedef enum logic [3:0] {
        S_IDLE, S_SHUFFLE, S_DEAL, S_P_TURN, S_P_CARD, S_P_HOLD,
        S_D_TURN, S_D_CARD, S_D_HOLD, S_SETTLE, S_DONE
    } state_e;

    localparam logic [1:0] RES_NONE = 2'b00;
    localparam logic [1:0] RES_WIN  = 2'b01;
    localparam logic [1:0] RES_LOSE = 2'b10;
    localparam logic [1:0] RES_TIE  = 2'b11;

    localparam int DEF_BJ_LIMIT     = 21;
    localparam int DEF_DEALER_STAND = 17;

endpackage

// File: rtl/hold_timer.sv
// Display-hold down-counter: load starts a CYCLES-long window, expired pulses
// in its final cycle.
module hold_timer #(
    parameter int CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    output logic expired
);
    localparam int CW = (CYCLES > 1) ? $clog2(CYCLES + 1) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          run_q, run_d;

    always_comb begin
        cnt_d = cnt_q;
        run_d = run_q;
        if (load) begin
            cnt_d = CW'(CYCLES - 1);
            run_d = 1'b1;
        end else if (run_q) begin
            if (cnt_q == '0) run_d = 1'b0;
            else             cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            run_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            run_q <= run_d;
        end
    end

    assign expired = run_q && (cnt_q == '0);

endmodule

// File: rtl/blackjack_table_ctrl.sv
// Multi-seat blackjack round sequencer: shuffle, deal, player turns, dealer
// draw and settlement, with all outputs registered from the next state.
module blackjack_table_ctrl
    import blackjack_pkg::*;
#(
    parameter int NUM_PLAYERS  = 2,
    parameter int HAND_W       = 6,
    parameter int DEALER_STAND = DEF_DEALER_STAND,
    parameter int BJ_LIMIT     = DEF_BJ_LIMIT,
    parameter int HOLD_CYCLES  = 100_000_000,
    parameter int PIDX_W       = $clog2(NUM_PLAYERS + 1)
) (
    input  logic                          i_Clk,
    input  logic                          i_Reset_n,
    input  logic                          i_NewGame,
    input  logic                          i_Hit,
    input  logic                          i_Stay,
    input  logic                          i_Shuffled,
    input  logic                          i_CardOK,
    input  logic [NUM_PLAYERS*HAND_W-1:0] i_HandP,
    input  logic [HAND_W-1:0]             i_HandD,
    output logic                          o_ActShuffler,
    output logic                          o_CardReq,
    output logic [PIDX_W-1:0]             o_CardDest,
    output logic [PIDX_W-1:0]             o_ActivePlayer,
    output logic                          o_Hit_P,
    output logic                          o_Stay_P,
    output logic                          o_Hit_D,
    output logic                          o_Stay_D,
    output logic                          o_ShwHnd_D,
    output logic [2*NUM_PLAYERS-1:0]      o_Result,
    output logic                          o_Done
);
    localparam int DW = $clog2(2 * NUM_PLAYERS + 2);
    localparam logic [HAND_W-1:0] LIMIT = HAND_W'(BJ_LIMIT);
    localparam logic [HAND_W-1:0] STAND = HAND_W'(DEALER_STAND);
    localparam logic [PIDX_W-1:0] DEALER = PIDX_W'(NUM_PLAYERS);

    state_e                   state_q, state_d;
    logic [PIDX_W-1:0]        active_q, active_d, dest_q, dest_d;
    logic [DW-1:0]            deal_q, deal_d;
    logic [2*NUM_PLAYERS-1:0] result_q, result_d;
    logic [NUM_PLAYERS-1:0]   bust_q, bust_d;
    logic req_q, req_d, shuf_q, shuf_d, hit_p_q, hit_p_d, stay_p_q, stay_p_d;
    logic hit_d_q, hit_d_d, stay_d_q, stay_d_d, shw_q, shw_d, done_q, done_d;
    logic load, expired;
    logic [HAND_W-1:0] act_hand, ph;
    logic [PIDX_W-1:0] deal_dest;

    hold_timer #(.CYCLES(HOLD_CYCLES)) u_hold (
        .clk(i_Clk), .rst_n(i_Reset_n), .load(load), .expired(expired)
    );

    always_comb begin
        act_hand = '0;
        for (int k = 0; k < NUM_PLAYERS; k++)
            if (active_q == PIDX_W'(k)) act_hand = i_HandP[k*HAND_W +: HAND_W];
        // Deal order wraps once: seats 0..N then 0..N again.
        if (deal_q > DW'(NUM_PLAYERS)) deal_dest = PIDX_W'(deal_q - DW'(NUM_PLAYERS + 1));
        else                           deal_dest = PIDX_W'(deal_q);
    end

    always_comb begin
        state_d  = state_q;   active_d = active_q;  dest_d   = dest_q;
        deal_d   = deal_q;    result_d = result_q;  bust_d   = bust_q;
        req_d    = req_q;     shuf_d   = shuf_q;    hit_p_d  = hit_p_q;
        stay_p_d = stay_p_q;  hit_d_d  = hit_d_q;   stay_d_d = stay_d_q;
        shw_d    = shw_q;     done_d   = done_q;    load     = 1'b0;
        ph       = '0;
        case (state_q)
            S_IDLE, S_DONE: if (i_NewGame) begin
                state_d = S_SHUFFLE; shuf_d = 1'b1; done_d = 1'b0; shw_d = 1'b0;
                result_d = '0; bust_d = '0; active_d = '0;
            end
            S_SHUFFLE: if (i_Shuffled) begin
                state_d = S_DEAL; shuf_d = 1'b0; deal_d = '0; req_d = 1'b1; dest_d = '0;
            end
            S_DEAL: begin
                if (i_CardOK && req_q) begin
                    req_d = 1'b0;
                    if (deal_q == DW'(2 * NUM_PLAYERS + 1)) begin
                        state_d = S_P_TURN; active_d = '0;
                    end else begin
                        deal_d = deal_q + DW'(1);
                    end
                end else if (!req_q) begin
                    req_d = 1'b1; dest_d = deal_dest;
                end
            end
            S_P_TURN: begin
                if (act_hand == LIMIT) begin
                    state_d = S_P_HOLD; stay_p_d = 1'b1; load = 1'b1;
                end else if (i_Hit) begin
                    state_d = S_P_CARD; req_d = 1'b1; dest_d = active_q;
                end else if (i_Stay) begin
                    state_d = S_P_HOLD; stay_p_d = 1'b1; load = 1'b1;
                end
            end
            S_P_CARD: if (i_CardOK && req_q) begin
                state_d = S_P_HOLD; req_d = 1'b0; hit_p_d = 1'b1; load = 1'b1;
            end
            S_P_HOLD: if (expired) begin
                hit_p_d = 1'b0; stay_p_d = 1'b0;
                if (hit_p_q && act_hand <= LIMIT) begin
                    state_d = S_P_TURN;
                end else begin
                    for (int k = 0; k < NUM_PLAYERS; k++)
                        if (active_q == PIDX_W'(k) && act_hand > LIMIT) begin
                            result_d[2*k +: 2] = RES_LOSE;
                            bust_d[k]          = 1'b1;
                        end
                    if (active_q == PIDX_W'(NUM_PLAYERS - 1)) begin
                        state_d  = (&bust_d) ? S_SETTLE : S_D_TURN;
                        active_d = DEALER;
                    end else begin
                        state_d  = S_P_TURN;
                        active_d = active_q + PIDX_W'(1);
                    end
                end
            end
            S_D_TURN: begin
                if (i_HandD < STAND) begin
                    state_d = S_D_CARD; req_d = 1'b1; dest_d = DEALER;
                end else begin
                    state_d = S_D_HOLD; stay_d_d = 1'b1; load = 1'b1;
                end
            end
            S_D_CARD: if (i_CardOK && req_q) begin
                state_d = S_D_HOLD; req_d = 1'b0; hit_d_d = 1'b1; load = 1'b1;
            end
            S_D_HOLD: if (expired) begin
                hit_d_d = 1'b0; stay_d_d = 1'b0;
                state_d = hit_d_q ? S_D_TURN : S_SETTLE;
            end
            S_SETTLE: begin
                for (int k = 0; k < NUM_PLAYERS; k++) begin
                    ph = i_HandP[k*HAND_W +: HAND_W];
                    if (!bust_q[k]) begin
                        if (i_HandD > LIMIT || ph > i_HandD) result_d[2*k +: 2] = RES_WIN;
                        else if (ph == i_HandD)              result_d[2*k +: 2] = RES_TIE;
                        else                                 result_d[2*k +: 2] = RES_LOSE;
                    end
                end
                state_d = S_DONE; done_d = 1'b1; shw_d = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            state_q  <= S_IDLE; active_q <= '0;   dest_q   <= '0;
            deal_q   <= '0;     result_q <= '0;   bust_q   <= '0;
            req_q    <= 1'b0;   shuf_q   <= 1'b0; hit_p_q  <= 1'b0;
            stay_p_q <= 1'b0;   hit_d_q  <= 1'b0; stay_d_q <= 1'b0;
            shw_q    <= 1'b0;   done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;  active_q <= active_d; dest_q   <= dest_d;
            deal_q   <= deal_d;   result_q <= result_d; bust_q   <= bust_d;
            req_q    <= req_d;    shuf_q   <= shuf_d;   hit_p_q  <= hit_p_d;
            stay_p_q <= stay_p_d; hit_d_q  <= hit_d_d;  stay_d_q <= stay_d_d;
            shw_q    <= shw_d;    done_q   <= done_d;
        end
    end

    assign o_ActShuffler  = shuf_q;
    assign o_CardReq      = req_q;
    assign o_CardDest     = dest_q;
    assign o_ActivePlayer = active_q;
    assign o_Hit_P        = hit_p_q;
    assign o_Stay_P       = stay_p_q;
    assign o_Hit_D        = hit_d_q;
    assign o_Stay_D       = stay_d_q;
    assign o_ShwHnd_D     = shw_q;
    assign o_Result       = result_q;
    assign o_Done         = done_q;

endmodule

// File: tb/tb_blackjack_table_ctrl.sv
// Directed bench for blackjack_table_ctrl: two seats, 4-cycle hold, a bench-side
// card adder that serves requested cards from hand-written deal tables.
module tb_blackjack_table_ctrl;
    localparam int N    = 2;
    localparam int HW   = 6;
    localparam int HOLD = 4;
    localparam int PW   = $clog2(N + 1);

    localparam int L_HIT_P = 0, L_STAY_P = 1, L_HIT_D = 2, L_STAY_D = 3, L_DONE = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          i_Reset_n = 1'b0, i_NewGame = 1'b0, i_Hit = 1'b0, i_Stay = 1'b0;
    logic          i_Shuffled = 1'b0, i_CardOK = 1'b0;
    logic [N*HW-1:0] i_HandP;
    logic [HW-1:0] hp [N];
    logic [HW-1:0] hd = '0;
    logic          o_ActShuffler, o_CardReq, o_Hit_P, o_Stay_P, o_Hit_D, o_Stay_D;
    logic          o_ShwHnd_D, o_Done;
    logic [PW-1:0] o_CardDest, o_ActivePlayer;
    logic [2*N-1:0] o_Result;

    assign i_HandP = {hp[1], hp[0]};

    blackjack_table_ctrl #(
        .NUM_PLAYERS(N), .HAND_W(HW), .DEALER_STAND(17), .BJ_LIMIT(21), .HOLD_CYCLES(HOLD)
    ) dut (
        .i_Clk(clk), .i_Reset_n(i_Reset_n), .i_NewGame(i_NewGame), .i_Hit(i_Hit),
        .i_Stay(i_Stay), .i_Shuffled(i_Shuffled), .i_CardOK(i_CardOK),
        .i_HandP(i_HandP), .i_HandD(hd), .o_ActShuffler(o_ActShuffler),
        .o_CardReq(o_CardReq), .o_CardDest(o_CardDest), .o_ActivePlayer(o_ActivePlayer),
        .o_Hit_P(o_Hit_P), .o_Stay_P(o_Stay_P), .o_Hit_D(o_Hit_D), .o_Stay_D(o_Stay_D),
        .o_ShwHnd_D(o_ShwHnd_D), .o_Result(o_Result), .o_Done(o_Done)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic logic led(input int sel);
        case (sel)
            L_HIT_P:  return o_Hit_P;
            L_STAY_P: return o_Stay_P;
            L_HIT_D:  return o_Hit_D;
            L_STAY_D: return o_Stay_D;
            L_DONE:   return o_Done;
            default:  return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] all_outs();
        return 32'({o_ActShuffler, o_CardReq, o_CardDest, o_ActivePlayer, o_Hit_P,
                    o_Stay_P, o_Hit_D, o_Stay_D, o_ShwHnd_D, o_Result, o_Done});
    endfunction

    task automatic press(input logic hit, input logic stay);
        i_Hit = hit; i_Stay = stay;
        tick();
        i_Hit = 1'b0; i_Stay = 1'b0;
    endtask

    // Bench card adder: waits for a request, checks the seat, pulses CardOK,
    // and updates the hand the following cycle.
    task automatic serve(input int dest, input int val);
        int n = 0;
        while (!o_CardReq && n < 50) begin tick(); n++; end
        chk("card_req", 32'(o_CardReq), 1);
        chk("card_dest", 32'(o_CardDest), dest);
        i_CardOK = 1'b1;
        tick();
        i_CardOK = 1'b0;
        if (dest == N) hd = hd + HW'(val);
        else           hp[dest] = hp[dest] + HW'(val);
    endtask

    task automatic deal(input int a0, input int a1, input int a2,
                        input int b0, input int b1, input int b2);
        serve(0, a0); serve(1, a1); serve(2, a2);
        serve(0, b0); serve(1, b1); serve(2, b2);
    endtask

    task automatic start_round();
        hp[0] = '0; hp[1] = '0; hd = '0;
        i_NewGame = 1'b1;
        tick();
        i_NewGame = 1'b0;
        chk("shuffler_on", 32'(o_ActShuffler), 1);
        i_Shuffled = 1'b1;
        tick();
        i_Shuffled = 1'b0;
        chk("shuffler_off", 32'(o_ActShuffler), 0);
    endtask

    task automatic wait_high(input int sel, input string tag, input int exp_n);
        int n = 0;
        while (!led(sel) && n < 50) begin tick(); n++; end
        chk(tag, 32'(n), 32'(exp_n));
    endtask

    task automatic wait_low(input int sel, input string tag, input int exp_n);
        int n = 0;
        while (led(sel) && n < 50) begin tick(); n++; end
        chk(tag, 32'(n), 32'(exp_n));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        hp[0] = '0; hp[1] = '0;
        tick(); tick();
        chk("reset_outs", all_outs(), 0);
        i_Reset_n = 1'b1;
        tick();

        // Round 1: P0=17, P1=18, D=18, everyone stays.
        start_round();
        deal(10, 9, 10, 7, 9, 8);
        chk("r1_active0", 32'(o_ActivePlayer), 0);
        press(1'b0, 1'b1);
        chk("r1_stay_p0", 32'(o_Stay_P), 1);
        wait_low(L_STAY_P, "r1_hold_len", HOLD);
        chk("r1_active1", 32'(o_ActivePlayer), 1);
        press(1'b0, 1'b1);
        wait_low(L_STAY_P, "r1_hold_p1", HOLD);
        wait_high(L_STAY_D, "r1_dealer_stay", 1);
        wait_low(L_STAY_D, "r1_hold_d", HOLD);
        wait_high(L_DONE, "r1_settle_lat", 1);
        chk("r1_result", 32'(o_Result), 32'h0E);
        chk("r1_show", 32'(o_ShwHnd_D), 1);

        // Round 2: P0=16 busts to 22, P1=19, dealer 16 draws to 24.
        start_round();
        deal(10, 10, 10, 6, 9, 6);
        i_NewGame = 1'b1;
        tick();
        i_NewGame = 1'b0;
        chk("r2_newgame_ignored", 32'(o_ActShuffler), 0);
        chk("r2_active0", 32'(o_ActivePlayer), 0);
        press(1'b1, 1'b1);
        chk("r2_hitstay_req", 32'(o_CardReq), 1);
        serve(0, 6);
        chk("r2_hit_led", 32'(o_Hit_P), 1);
        press(1'b1, 1'b0);
        chk("r2_hold_ignores_hit", 32'(o_CardReq), 0);
        wait_low(L_HIT_P, "r2_hold_rest", HOLD - 1);
        chk("r2_p0_bust", 32'(o_Result), 32'h2);
        chk("r2_active1", 32'(o_ActivePlayer), 1);
        press(1'b0, 1'b1);
        wait_low(L_STAY_P, "r2_hold_p1", HOLD);
        serve(2, 8);
        chk("r2_hit_d", 32'(o_Hit_D), 1);
        wait_low(L_HIT_D, "r2_hold_hit_d", HOLD);
        wait_high(L_STAY_D, "r2_dealer_stay", 1);
        wait_low(L_STAY_D, "r2_hold_d", HOLD);
        wait_high(L_DONE, "r2_settle_lat", 1);
        chk("r2_result", 32'(o_Result), 32'h6);

        // Round 3: both players bust; dealer must not play.
        start_round();
        deal(10, 10, 10, 6, 5, 7);
        press(1'b1, 1'b0);
        serve(0, 10);
        wait_low(L_HIT_P, "r3_hold_p0", HOLD);
        chk("r3_p0_bust", 32'(o_Result), 32'h2);
        chk("r3_active1", 32'(o_ActivePlayer), 1);
        press(1'b1, 1'b0);
        serve(1, 10);
        wait_low(L_HIT_P, "r3_hold_p1", HOLD);
        begin
            int n = 0;
            logic saw = 1'b0;
            while (!o_Done && n < 20) begin
                if (o_CardReq || o_Stay_D || o_Hit_D) saw = 1'b1;
                tick(); n++;
            end
            chk("r3_no_dealer", 32'(saw), 0);
            chk("r3_settle_lat", 32'(n), 1);
        end
        chk("r3_result", 32'(o_Result), 32'hA);

        // Round 4: P0 dealt 21 auto-stays; reset during P1's card request.
        start_round();
        deal(10, 10, 10, 11, 5, 7);
        wait_high(L_STAY_P, "r4_autostay", 1);
        wait_low(L_STAY_P, "r4_hold_p0", HOLD);
        press(1'b1, 1'b0);
        chk("r4_req", 32'(o_CardReq), 1);
        chk("r4_dest", 32'(o_CardDest), 1);
        i_Reset_n = 1'b0;
        #1;
        chk("r4_reset_outs", all_outs(), 0);
        tick();
        i_Reset_n = 1'b1;
        tick();
        start_round();
        serve(0, 10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
